// File: rtl/lemming_world.sv
// Lemming corridor world: walker position stepping between two walls, with wall-bump and direction-error pulses.
// Latency: pos, bump_left/right and dir_err update at the step edge; bump_cnt follows one cycle after each bump pulse.
// Backpressure: none; the walk inputs are sampled only at step cycles, and outputs are pulses or levels the walker must react to.
// Ports: clk, rst (sync, active-high); walk_left/walk_right (walker heading);
//        bump_left/bump_right/dir_err (one-cycle registered pulses); pos (position 0..MAX_POS);
//        bump_cnt (saturating bump total since reset).
module lemming_world #(
    parameter int MAX_POS     = 15,
    parameter int POS_W       = 4,
    parameter int STEP_CYCLES = 4,
    parameter int RESET_POS   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             walk_left,
    input  logic             walk_right,
    output logic             bump_left,
    output logic             bump_right,
    output logic [POS_W-1:0] pos,
    output logic [7:0]       bump_cnt,
    output logic             dir_err
);

    // A counter width of at least 1 keeps STEP_CYCLES=1 legal; the counter then sits at 0 and every cycle is a step.
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] POS_RESET = POS_W'(RESET_POS);

    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             bump_left_q, bump_left_d;
    logic             bump_right_q, bump_right_d;
    logic             dir_err_q, dir_err_d;
    logic [7:0]       bump_cnt_q, bump_cnt_d;
    logic             step;

    always_comb begin
        step         = (step_cnt_q == CNT_LAST);
        step_cnt_d   = step ? '0 : step_cnt_q + CNT_W'(1);
        pos_d        = pos_q;
        bump_left_d  = 1'b0;
        bump_right_d = 1'b0;
        dir_err_d    = 1'b0;

        // The counter reacts to the already-registered pulse, so it trails the pulse by one cycle.
        bump_cnt_d = bump_cnt_q;
        if ((bump_left_q || bump_right_q) && (bump_cnt_q != 8'hFF)) begin
            bump_cnt_d = bump_cnt_q + 8'd1;
        end

        if (step) begin
            if (walk_left && !walk_right) begin
                if (pos_q == '0) begin
                    bump_left_d = 1'b1;
                end else begin
                    pos_d = pos_q - POS_W'(1);
                end
            end else if (walk_right && !walk_left) begin
                if (pos_q == POS_MAX) begin
                    bump_right_d = 1'b1;
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end else begin
                // Both or neither heading: the walker is confused, stand still and flag it.
                dir_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q   <= '0;
            pos_q        <= POS_RESET;
            bump_left_q  <= 1'b0;
            bump_right_q <= 1'b0;
            dir_err_q    <= 1'b0;
            bump_cnt_q   <= 8'd0;
        end else begin
            step_cnt_q   <= step_cnt_d;
            pos_q        <= pos_d;
            bump_left_q  <= bump_left_d;
            bump_right_q <= bump_right_d;
            dir_err_q    <= dir_err_d;
            bump_cnt_q   <= bump_cnt_d;
        end
    end

    assign pos        = pos_q;
    assign bump_left  = bump_left_q;
    assign bump_right = bump_right_q;
    assign dir_err    = dir_err_q;
    assign bump_cnt   = bump_cnt_q;

endmodule
